// File: rtl/ahb_mst.sv
// rtl/ahb_mst.sv - AHB-Lite initiator issuing SINGLE and INCR4 transfers from simple commands.
// Define AHB_MST_ERR_EN to abort commands on an ERROR response.
module ahb_mst #(
    parameter int ADDR_W = 32
) (
    input  logic              hclk_i,
    input  logic              hreset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [2:0]        cmd_size_i,
    input  logic              cmd_incr4_i,
    input  logic [127:0]      cmd_wdata_i,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              done_o,
    output logic              err_o,
    output logic              hsel_o,
    output logic [ADDR_W-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [31:0]       hwdata_o,
    input  logic              hready_i,
    input  logic [31:0]       hrdata_i,
    input  logic [1:0]        hresp_i
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_DONE} state_t;

    state_t            state, state_nxt;
    logic              started;
    logic              cmd_write, cmd_incr4;
    logic [2:0]        cmd_size;
    logic [127:0]      cmd_wdata;
    logic [ADDR_W-1:0] addr_q, start_addr;
    logic [1:0]        beat_q;
    logic              dph_valid, dph_write;
    logic [31:0]       hwdata_q, rdata_q;
    logic              rvalid_q;
    logic              accept, addr_done, dph_done, err_hit, resp_ok;

    assign accept    = (state == S_IDLE) && cmd_valid_i && started;
    assign addr_done = (state == S_ADDR) && hready_i;
    assign dph_done  = dph_valid && hready_i;

`ifdef AHB_MST_ERR_EN
    logic err_q;

    // First cycle of the two-cycle ERROR response; the FSM drops to IDLE on the bus next cycle
    assign err_hit = dph_valid && !hready_i && (hresp_i == 2'b01);
    assign resp_ok = (hresp_i != 2'b01) && !err_q;
    assign err_o   = done_o && err_q;

    always_ff @(posedge hclk_i or negedge hreset_n) begin
        if (!hreset_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_resp;

    assign unused_resp = ^hresp_i;
    assign err_hit     = 1'b0;
    assign resp_ok     = 1'b1;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        start_addr = cmd_addr_i;
        if (cmd_incr4_i) begin
            start_addr[3:0] = 4'h0;
        end else if (cmd_size_i == 3'b001) begin
            start_addr[0] = 1'b0;
        end else if (cmd_size_i == 3'b010) begin
            start_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        htrans_o    = 2'b00;
        done_o      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready_o = started;
                if (cmd_valid_i && started) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                htrans_o = (beat_q == 2'd0) ? 2'b10 : 2'b11;
                if (err_hit) begin
                    state_nxt = S_LAST;
                end else if (hready_i && (!cmd_incr4 || beat_q == 2'd3)) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                if (hready_i) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk_i or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= S_IDLE;
            started   <= 1'b0;
            cmd_write <= 1'b0;
            cmd_incr4 <= 1'b0;
            cmd_size  <= 3'b000;
            cmd_wdata <= '0;
            addr_q    <= '0;
            beat_q    <= 2'd0;
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            hwdata_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            started  <= 1'b1;
            rvalid_q <= 1'b0;
            if (accept) begin
                cmd_write <= cmd_write_i;
                cmd_incr4 <= cmd_incr4_i;
                cmd_size  <= cmd_incr4_i ? 3'b010 : cmd_size_i;
                cmd_wdata <= cmd_wdata_i;
                addr_q    <= start_addr;
                beat_q    <= 2'd0;
            end
            // Address phase of beat n completes: its data phase starts and beat n+1 is presented
            if (addr_done) begin
                beat_q    <= beat_q + 2'd1;
                dph_valid <= 1'b1;
                dph_write <= cmd_write;
                hwdata_q  <= cmd_write ? cmd_wdata[{beat_q, 5'b00000} +: 32] : 32'h0;
                if (cmd_incr4 && beat_q != 2'd3) begin
                    addr_q <= addr_q + ADDR_W'(4);
                end
            end else if (dph_done) begin
                dph_valid <= 1'b0;
            end
            if (dph_done && !dph_write && resp_ok) begin
                rdata_q  <= hrdata_i;
                rvalid_q <= 1'b1;
            end
        end
    end

    assign hsel_o        = htrans_o[1];
    assign haddr_o       = addr_q;
    assign hwrite_o      = cmd_write;
    assign hsize_o       = cmd_size;
    assign hburst_o      = cmd_incr4 ? 3'b011 : 3'b000;
    assign hwdata_o      = hwdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;

endmodule

// File: tb/tb_ahb_mst.sv
// tb/tb_ahb_mst.sv - self-checking bench for ahb_mst with a behavioural AHB slave/memory and a command-level model
module tb_ahb_mst;

    logic         hclk_i = 1'b0;
    logic         hreset_n = 1'b0;
    logic         cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_incr4_i;
    logic [31:0]  cmd_addr_i;
    logic [2:0]   cmd_size_i;
    logic [127:0] cmd_wdata_i;
    logic [31:0]  rdata_o, haddr_o, hwdata_o, hrdata_i;
    logic         rdata_valid_o, done_o, err_o, hsel_o, hwrite_o, hready_i;
    logic [1:0]   htrans_o, hresp_i;
    logic [2:0]   hsize_o, hburst_o;

    always #5 hclk_i = ~hclk_i;

    ahb_mst #(.ADDR_W(32)) dut (
        .hclk_i(hclk_i), .hreset_n(hreset_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_incr4_i(cmd_incr4_i),
        .cmd_wdata_i(cmd_wdata_i), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .done_o(done_o), .err_o(err_o), .hsel_o(hsel_o), .haddr_o(haddr_o),
        .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o),
        .hwdata_o(hwdata_o), .hready_i(hready_i), .hrdata_i(hrdata_i), .hresp_i(hresp_i)
    );

    // Behavioural slave: 64-word memory preloaded with word i = i, programmable wait and ERROR injection
    logic [31:0] mem [64];
    bit          loaded = 1'b0;
    logic        sp_valid, sp_write;
    logic [7:0]  sp_addr;
    logic [2:0]  sp_size, sp_nb;
    logic [1:0]  sp_lo;
    int          wait_cnt, err_stage;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF, stall_addr = 32'hFFFF_FFFF;
    int          stall_n = 0;

    assign sp_nb    = 3'd1 << sp_size;
    assign sp_lo    = sp_addr[1:0] & ~(sp_nb[1:0] - 2'd1);
    assign hready_i = !sp_valid ? 1'b1 : (err_stage == 1) ? 1'b0 : (wait_cnt == 0);
    assign hresp_i  = (sp_valid && err_stage != 0) ? 2'b01 : 2'b00;
    assign hrdata_i = (sp_valid && !sp_write) ? mem[sp_addr[7:2]] : 32'h0;

    always @(posedge hclk_i or negedge hreset_n) begin
        if (!hreset_n) begin
            sp_valid  <= 1'b0;
            sp_write  <= 1'b0;
            sp_addr   <= 8'h0;
            sp_size   <= 3'b0;
            wait_cnt  <= 0;
            err_stage <= 0;
            if (!loaded) begin
                for (int i = 0; i < 64; i++) mem[i] <= i;
                loaded <= 1'b1;
            end
        end else if (hready_i) begin
            if (sp_valid && sp_write && err_stage == 0) begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= int'(sp_lo) && b < int'(sp_lo) + int'(sp_nb))
                        mem[sp_addr[7:2]][8*b +: 8] <= hwdata_o[8*b +: 8];
                end
            end
            sp_valid  <= hsel_o && htrans_o[1];
            sp_write  <= hwrite_o;
            sp_addr   <= haddr_o[7:0];
            sp_size   <= hsize_o;
            wait_cnt  <= (htrans_o[1] && haddr_o == stall_addr) ? stall_n : 0;
            err_stage <= (htrans_o[1] && err_en && haddr_o == err_addr) ? 1 : 0;
        end else begin
            if (err_stage == 1) err_stage <= 2;
            else if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
        end
    end

    // Monitor: read beats, completions, per-cycle HTRANS while busy, accepted address phases, hold stability
    logic [31:0] rd_q [$];
    logic [1:0]  ht_q [$];
    logic [38:0] acc_q [$];
    int          done_cnt = 0, hold_err = 0;
    logic        done_err = 1'b0, done_rv = 1'b0;
    logic        p_hready = 1'b1;
    logic [1:0]  p_htrans = 2'b00, p_hresp = 2'b00;
    logic [31:0] p_haddr = 32'h0, p_hwdata = 32'h0;

    always @(negedge hclk_i) begin
        if (hreset_n) begin
            if (rdata_valid_o) rd_q.push_back(rdata_o);
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_err <= err_o;
                done_rv  <= rdata_valid_o;
            end
            if (!cmd_ready_o) ht_q.push_back(htrans_o);
            if (htrans_o[1] && hready_i) acc_q.push_back({hwrite_o, hsize_o, hburst_o, haddr_o});
            if (!cmd_ready_o && !p_hready && p_hresp == 2'b00 &&
                (htrans_o != p_htrans || haddr_o != p_haddr || hwdata_o != p_hwdata))
                hold_err <= hold_err + 1;
        end
        p_hready <= hready_i;
        p_hresp  <= hresp_i;
        p_htrans <= htrans_o;
        p_haddr  <= haddr_o;
        p_hwdata <= hwdata_o;
    end

    int          n_chk = 0, errs = 0;
    logic [31:0] ref_mem [64];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdq(input int i);
        return (rd_q.size() > i) ? rd_q[i] : 32'hx;
    endfunction

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input bit incr4, input logic [127:0] wdata);
        @(negedge hclk_i);
        chk("ready_before_cmd", cmd_ready_o, 1);
        rd_q.delete();
        ht_q.delete();
        acc_q.delete();
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_size_i  = size;
        cmd_incr4_i = incr4;
        cmd_wdata_i = wdata;
        @(posedge hclk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int t = 0; t < 100 && done_cnt == d0; t++) @(posedge hclk_i);
        chk("done_count", done_cnt - d0, 1);
    endtask

    // Full command with model-derived expectations: bus trace, timing, data and memory effects
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input bit incr4, input logic [127:0] wdata, input int sbeat, input int sn);
        int          nb, bytes, d0;
        logic [31:0] base;
        logic [1:0]  ht_exp [$];
        nb         = incr4 ? 4 : 1;
        bytes      = incr4 ? 4 : (1 << size);
        base       = incr4 ? (addr & ~32'hF) : (addr & ~(bytes - 1));
        stall_addr = base + 4 * sbeat;
        stall_n    = sn;
        d0         = done_cnt;
        issue(wr, addr, size, incr4, wdata);
        wait_done(d0);
        for (int b = 0; b < nb; b++)
            repeat (1 + ((b > 0 && sbeat == b - 1) ? sn : 0)) ht_exp.push_back(b == 0 ? 2'b10 : 2'b11);
        repeat (1 + ((sbeat == nb - 1) ? sn : 0)) ht_exp.push_back(2'b00);
        ht_exp.push_back(2'b00);
        chk("busy_cycles", ht_q.size(), ht_exp.size());
        for (int i = 0; i < ht_exp.size() && i < ht_q.size(); i++)
            chk($sformatf("htrans[%0d]", i), ht_q[i], ht_exp[i]);
        chk("addr_phases", acc_q.size(), nb);
        for (int b = 0; b < nb && b < acc_q.size(); b++)
            chk($sformatf("addr_phase[%0d]", b), acc_q[b],
                {wr, incr4 ? 3'd2 : size, incr4 ? 3'd3 : 3'd0, base + 32'(4 * b)});
        chk("err_at_done", done_err, 0);
        if (wr) begin
            if (incr4) begin
                for (int b = 0; b < 4; b++) ref_mem[(base >> 2) + b] = wdata[32*b +: 32];
            end else begin
                for (int k = 0; k < bytes; k++)
                    ref_mem[base >> 2][8*(int'(base[1:0]) + k) +: 8] = wdata[8*(int'(base[1:0]) + k) +: 8];
            end
            chk("write_read_beats", rd_q.size(), 0);
            chk("write_rv_at_done", done_rv, 0);
        end else begin
            chk("read_beats", rd_q.size(), nb);
            for (int b = 0; b < nb; b++)
                chk($sformatf("rdata[%0d]", b), rdq(b), ref_mem[((base >> 2) + b) & 63]);
            chk("read_rv_at_done", done_rv, 1);
        end
    endtask

    logic [127:0] wd;
    logic [31:0]  ra;
    bit           rw, ri;
    int           d0;

    initial begin
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_incr4_i = 1'b0;
        cmd_addr_i  = 32'h0;
        cmd_size_i  = 3'b0;
        cmd_wdata_i = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = i;

        repeat (3) @(posedge hclk_i);
        @(negedge hclk_i);
        chk("reset_outputs", {cmd_ready_o, rdata_o, rdata_valid_o, done_o, err_o, hsel_o, haddr_o,
                              htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o}, 0);
        hreset_n = 1'b1;
        @(posedge hclk_i);
        #1 chk("ready_after_first_edge", cmd_ready_o, 1);

        run_cmd(0, 32'h10, 3'b010, 0, 128'h0, 0, 0);
        chk("single_rd_0x10", rdq(0), 32'h4);

        run_cmd(1, 32'h20, 3'b010, 0, 128'h5555, 0, 0);
        run_cmd(0, 32'h20, 3'b010, 0, 128'h0, 0, 0);
        chk("readback_0x20", rdq(0), 32'h5555);

        run_cmd(1, 32'h32, 3'b001, 0, 128'h5555_5555, 0, 0);
        run_cmd(0, 32'h30, 3'b010, 0, 128'h0, 0, 0);
        chk("halfword_merge_0x30", rdq(0), 32'h5555_000C);

        ref_mem[12] = 32'hC;
        run_cmd(1, 32'h30, 3'b010, 0, 128'hC, 0, 0);
        run_cmd(0, 32'h30, 3'b000, 1, 128'h0, 0, 0);
        chk("incr4_rd_beat0", rdq(0), 32'hC);
        chk("incr4_rd_beat3", rdq(3), 32'hF);

        wd = {$urandom, $urandom, $urandom, $urandom};
        run_cmd(1, 32'h47, 3'b000, 1, wd, 2, 2);
        chk("stall_hold", hold_err, 0);
        run_cmd(0, 32'h40, 3'b010, 1, 128'h0, 0, 0);
        chk("stall_readback_beat2", rdq(2), wd[95:64]);

`ifdef AHB_MST_ERR_EN
        err_en   = 1'b1;
        err_addr = 32'h34;
        stall_n  = 0;
        d0       = done_cnt;
        issue(0, 32'h30, 3'b010, 1, 128'h0);
        wait_done(d0);
        err_en = 1'b0;
        chk("err_busy_cycles", ht_q.size(), 5);
        chk("err_htrans", {ht_q[0], ht_q[1], ht_q[2], ht_q[3], ht_q[4]}, {2'b10, 2'b11, 2'b11, 2'b00, 2'b00});
        chk("err_addr_phases", acc_q.size(), 2);
        chk("err_read_beats", rd_q.size(), 1);
        chk("err_beat0_data", rdq(0), 32'hC);
        chk("err_at_done", done_err, 1);
        chk("err_rv_at_done", done_rv, 0);
`endif

        // Reset in the middle of an INCR4 read
        stall_n = 0;
        d0      = done_cnt;
        issue(0, 32'h80, 3'b010, 1, 128'h0);
        @(negedge hclk_i);
        @(negedge hclk_i);
        chk("mid_burst_seq", htrans_o, 2'b11);
        #2 hreset_n = 1'b0;
        #1 chk("async_reset_outputs", {cmd_ready_o, rdata_o, rdata_valid_o, done_o, err_o, hsel_o, haddr_o,
                                       htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o}, 0);
        @(negedge hclk_i);
        hreset_n = 1'b1;
        repeat (8) @(posedge hclk_i);
        chk("no_done_after_reset", done_cnt - d0, 0);
        run_cmd(0, 32'h84, 3'b010, 0, 128'h0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            rw = 1'($urandom_range(1, 0));
            ri = ($urandom_range(2, 0) == 0);
            ra = 32'($urandom_range(255, 0));
            wd = {$urandom, $urandom, $urandom, $urandom};
            run_cmd(rw, ra, 3'($urandom_range(2, 0)), ri, wd,
                    ri ? $urandom_range(3, 0) : 0, $urandom_range(2, 0));
        end
        for (int i = 0; i < 64; i += 8)
            run_cmd(0, 32'(4 * i), 3'b010, 1, 128'h0, 0, 0);
        chk("final_hold", hold_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, errs);
        $finish;
    end

endmodule
